axis_data_unpack: RTL and testbench

AXIS_DATA_UNPACK -- requirements
Module: axis_data_unpack

---
 rtl/axis_data_pkg.sv | 29 ++
 rtl/sat_counter16.sv | 23 ++
 rtl/axis_data_unpack.sv | 197 +++++++++++++++++++
 tb/tb_axis_data_unpack.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_data_pkg.sv
// axis_data_pkg
//   Frame-format constants shared by the packer and the unpacker.
//   A frame is the payload word with the sequence byte appended below it,
//   {payload, seq}, cut LSB-first into AXIS_DATA_WIDTH-bit beats.
//   The sequence byte occupies bits [7:0] of beat 0, and the payload starts
//   at bit 8 of beat 0.
package axis_data_pkg;

  localparam int SEQ_W               = 8;
  localparam int DEF_DATA_WIDTH      = 1928;
  localparam int DEF_AXIS_DATA_WIDTH = 512;

  // Number of beats needed to carry one payload word plus its sequence byte.
  function automatic int calc_beats(input int data_width, input int axis_width);
    return (data_width + SEQ_W + axis_width - 1) / axis_width;
  endfunction

  // Beats per frame at the default widths (4).
  localparam int BEATS          = calc_beats(DEF_DATA_WIDTH, DEF_AXIS_DATA_WIDTH);
  // Number of payload bits carried in beat 0 at the default widths (504).
  localparam int PAYLOAD_OFFSET = DEF_AXIS_DATA_WIDTH - SEQ_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter16.sv
// sat_counter16
//   16-bit event counter that holds at 16'hFFFF instead of wrapping.
//   Ports:
//     clk   - clock, rising edge
//     rstn  - asynchronous active-low reset, clears the count
//     inc   - count one event this cycle
//     cnt   - current count
module sat_counter16 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= 16'h0000;
    end else if (inc && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'h0001;
    end
  end

endmodule

// File: rtl/axis_data_unpack.sv
// axis_data_unpack
//   Reassembles a DATA_WIDTH-bit payload word and its sequence byte from a
//   multi-beat AXI-Stream frame, checks frame length and sequence continuity,
//   and presents the word on a valid/ready output port.
//   Ports:
//     m_axis_c2h_aclk     - clock, rising edge
//     m_axis_c2h_aresetn  - asynchronous active-low reset
//     m_axis_c2h_tdata    - stream beat
//     m_axis_c2h_tkeep    - accepted, not used
//     m_axis_c2h_tlast    - last beat of the frame
//     m_axis_c2h_tvalid   - stream beat valid
//     m_axis_c2h_tready   - stream beat accepted
//     data_out            - reassembled payload word
//     data_out_seq        - sequence byte of the word on data_out
//     data_out_valid      - data_out holds an undelivered word
//     data_out_ready      - consumer takes the word
//     frame_cnt           - completed frames (wraps)
//     seq_err_cnt         - sequence discontinuities (saturates)
//     len_err_cnt         - malformed-length frames (saturates)
//
//   state | meaning
//   IDLE  | waiting for beat 0 of a frame
//   BODY  | collecting beats 1..BEATS-1, idx_q is the index of the next beat
//   DRAIN | frame ran long; dropping beats until tlast
module axis_data_unpack
  import axis_data_pkg::*;
#(
  parameter int DATA_WIDTH      = 1928,
  parameter int AXIS_DATA_WIDTH = 512
) (
  input  logic                       m_axis_c2h_aclk,
  input  logic                       m_axis_c2h_aresetn,
  input  logic [AXIS_DATA_WIDTH-1:0] m_axis_c2h_tdata,
  input  logic [63:0]                m_axis_c2h_tkeep,
  input  logic                       m_axis_c2h_tlast,
  input  logic                       m_axis_c2h_tvalid,
  output logic                       m_axis_c2h_tready,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [7:0]                 data_out_seq,
  output logic                       data_out_valid,
  input  logic                       data_out_ready,
  output logic [31:0]                frame_cnt,
  output logic [15:0]                seq_err_cnt,
  output logic [15:0]                len_err_cnt
);

  localparam int NUM_BEATS = calc_beats(DATA_WIDTH, AXIS_DATA_WIDTH);
  localparam int IDX_W     = (NUM_BEATS > 2) ? $clog2(NUM_BEATS) : 1;
  localparam int BUF_W     = (NUM_BEATS - 1) * AXIS_DATA_WIDTH;
  localparam int FRAME_W   = NUM_BEATS * AXIS_DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [BUF_W-1:0]   buf_q;
  logic [FRAME_W-1:0] frame_w;
  logic               ready_en_q;
  logic               beat_acc;
  logic               store_beat;
  logic               frame_done;
  logic               len_err;
  logic               seq_err;
  logic               first_q;
  logic [7:0]         exp_seq_q;
  logic               unused_bits;

  // Held low through reset and released by the first clock edge afterwards.
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  // The final beat is the only one that needs a free output register, so
  // backpressure is applied there alone; earlier beats keep streaming.
  assign m_axis_c2h_tready = ready_en_q &
                             ~((state_q == BODY) && (idx_q == LAST_IDX) &&
                               data_out_valid && !data_out_ready);
  assign beat_acc = m_axis_c2h_tvalid & m_axis_c2h_tready;

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    store_beat = 1'b0;
    frame_done = 1'b0;
    len_err    = 1'b0;
    if (beat_acc) begin
      case (state_q)
        IDLE: begin
          if (m_axis_c2h_tlast) begin
            len_err = 1'b1;
          end else begin
            store_beat = 1'b1;
            state_d    = BODY;
          end
        end
        BODY: begin
          if (idx_q == LAST_IDX) begin
            if (m_axis_c2h_tlast) begin
              frame_done = 1'b1;
              state_d    = IDLE;
            end else begin
              len_err = 1'b1;
              state_d = DRAIN;
            end
          end else if (m_axis_c2h_tlast) begin
            len_err = 1'b1;
            state_d = IDLE;
          end else begin
            store_beat = 1'b1;
          end
        end
        DRAIN: begin
          if (m_axis_c2h_tlast) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      idx_q <= '0;
    end else if (beat_acc) begin
      idx_q <= store_beat ? (idx_q + 1'b1) : '0;
    end
  end

  // Beats 0..BEATS-2 are buffered; the final beat is used straight off the
  // bus, so the frame buffer itself needs no reset.
  always_ff @(posedge m_axis_c2h_aclk) begin
    for (int b = 0; b < NUM_BEATS - 1; b++) begin
      if (store_beat && (idx_q == IDX_W'(b))) begin
        buf_q[b*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] <= m_axis_c2h_tdata;
      end
    end
  end

  assign frame_w     = {m_axis_c2h_tdata, buf_q};
  assign unused_bits = ^{m_axis_c2h_tkeep, frame_w[FRAME_W-1:DATA_WIDTH+SEQ_W]};

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      data_out       <= '0;
      data_out_seq   <= '0;
      data_out_valid <= 1'b0;
    end else if (frame_done) begin
      // Completion is only possible when the output is free or being
      // drained this cycle, so loading here never overwrites a live word.
      data_out       <= frame_w[DATA_WIDTH+SEQ_W-1:SEQ_W];
      data_out_seq   <= frame_w[SEQ_W-1:0];
      data_out_valid <= 1'b1;
    end else if (data_out_ready) begin
      data_out_valid <= 1'b0;
    end
  end

  assign seq_err = frame_done && !first_q && (frame_w[SEQ_W-1:0] != exp_seq_q);

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      first_q   <= 1'b1;
      exp_seq_q <= '0;
      frame_cnt <= '0;
    end else if (frame_done) begin
      first_q   <= 1'b0;
      exp_seq_q <= frame_w[SEQ_W-1:0] + 8'd1;
      frame_cnt <= frame_cnt + 32'd1;
    end
  end

  sat_counter16 u_seq_err_cnt (
    .clk  (m_axis_c2h_aclk),
    .rstn (m_axis_c2h_aresetn),
    .inc  (seq_err),
    .cnt  (seq_err_cnt)
  );

  sat_counter16 u_len_err_cnt (
    .clk  (m_axis_c2h_aclk),
    .rstn (m_axis_c2h_aresetn),
    .inc  (len_err),
    .cnt  (len_err_cnt)
  );

endmodule

// File: tb/tb_axis_data_unpack.sv
module tb_axis_data_unpack;

  localparam int DW  = 1928;
  localparam int AW  = 512;
  localparam int NB  = axis_data_pkg::BEATS;
  localparam int PO  = axis_data_pkg::PAYLOAD_OFFSET;
  localparam int FBW = NB * AW;

  logic          clk;
  logic          rstn;
  logic [AW-1:0] tdata;
  logic [63:0]   tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] data_out;
  logic [7:0]    data_out_seq;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [31:0]   frame_cnt;
  logic [15:0]   seq_err_cnt;
  logic [15:0]   len_err_cnt;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  logic [DW-1:0] exp_data_q[$];
  logic [7:0]    exp_seq_q[$];

  axis_data_unpack #(.DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW)) dut (
    .m_axis_c2h_aclk    (clk),
    .m_axis_c2h_aresetn (rstn),
    .m_axis_c2h_tdata   (tdata),
    .m_axis_c2h_tkeep   (tkeep),
    .m_axis_c2h_tlast   (tlast),
    .m_axis_c2h_tvalid  (tvalid),
    .m_axis_c2h_tready  (tready),
    .data_out           (data_out),
    .data_out_seq       (data_out_seq),
    .data_out_valid     (data_out_valid),
    .data_out_ready     (data_out_ready),
    .frame_cnt          (frame_cnt),
    .seq_err_cnt        (seq_err_cnt),
    .len_err_cnt        (len_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // Scoreboard: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rstn && data_out_valid && data_out_ready) begin
      chk("sb_word_expected", 64'(exp_data_q.size() != 0), 64'd1);
      if (exp_data_q.size() != 0) begin
        chk_data("sb_data", data_out, exp_data_q.pop_front());
        chk("sb_seq", 64'(data_out_seq), 64'(exp_seq_q.pop_front()));
      end
      delivered++;
    end
  end

  function automatic logic [FBW-1:0] build_frame(input logic [7:0] seq, input logic [DW-1:0] pl);
    logic [FBW-1:0] fb;
    fb = '0;
    fb[7:0]           = seq;
    fb[AW-1:8]        = pl[PO-1:0];
    fb[AW +: (DW-PO)] = pl[DW-1:PO];
    return fb;
  endfunction

  function automatic logic [DW-1:0] rand_payload();
    logic [2047:0] t;
    for (int i = 0; i < 64; i++) t[i*32 +: 32] = $urandom();
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] incr_payload();
    logic [DW-1:0] p;
    for (int i = 0; i < DW/8; i++) p[i*8 +: 8] = 8'(i);
    return p;
  endfunction

  task automatic send_beat(input logic [AW-1:0] d, input logic l);
    int  n;
    logic ok;
    n = 0;
    ok = 1'b0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = tready;
      @(posedge clk);
      #1;
      n++;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("beat_accepted", 64'(ok), 64'd1);
  endtask

  // nbeats beats with tlast on the last one; good frames are scoreboarded.
  task automatic send_frame(input logic [7:0] seq, input logic [DW-1:0] pl,
                            input int nbeats, input logic good);
    logic [FBW-1:0] fb;
    logic [AW-1:0]  d;
    fb = build_frame(seq, pl);
    if (good) begin
      exp_data_q.push_back(pl);
      exp_seq_q.push_back(seq);
    end
    for (int b = 0; b < nbeats; b++) begin
      if (b < NB) d = fb[b*AW +: AW];
      else        d = {16{$urandom()}};
      send_beat(d, b == nbeats - 1);
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_data_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("sb_drained", 64'(exp_data_q.size()), 64'd0);
  endtask

  task automatic apply_reset();
    tvalid = 1'b0;
    tlast  = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b0;
    exp_data_q.delete();
    exp_seq_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]  pa, pb;
    logic [FBW-1:0] fb;
    int             d0;

    rstn = 1'b0;
    tdata = '0;
    tkeep = '1;
    tlast = 1'b0;
    tvalid = 1'b0;
    data_out_ready = 1'b1;

    // Reset values
    #2;
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_valid", 64'(data_out_valid), 64'd0);
    chk_data("rst_data", data_out, '0);
    chk("rst_seq", 64'(data_out_seq), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_seq_err", 64'(seq_err_cnt), 64'd0);
    chk("rst_len_err", 64'(len_err_cnt), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    chk("tready_before_edge", 64'(tready), 64'd0);
    @(posedge clk);
    #1;
    chk("tready_after_edge", 64'(tready), 64'd1);

    // One good frame, incrementing bytes, seq 00, exact one-cycle latency
    pa = incr_payload();
    fb = build_frame(8'h00, pa);
    exp_data_q.push_back(pa);
    exp_seq_q.push_back(8'h00);
    for (int b = 0; b < NB - 1; b++) send_beat(fb[b*AW +: AW], 1'b0);
    chk("t1_valid_before_last", 64'(data_out_valid), 64'd0);
    send_beat(fb[(NB-1)*AW +: AW], 1'b1);
    chk("t1_valid_latency", 64'(data_out_valid), 64'd1);
    chk_data("t1_data", data_out, pa);
    chk("t1_seq", 64'(data_out_seq), 64'd0);
    wait_empty();
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t1_seq_err", 64'(seq_err_cnt), 64'd0);
    chk("t1_len_err", 64'(len_err_cnt), 64'd0);

    // Sequence wrap FE, FF, 00 accepted; 02 is a skip
    apply_reset();
    d0 = delivered;
    send_frame(8'hFE, rand_payload(), NB, 1'b1);
    send_frame(8'hFF, rand_payload(), NB, 1'b1);
    send_frame(8'h00, rand_payload(), NB, 1'b1);
    wait_empty();
    chk("t2_seq_err_after_wrap", 64'(seq_err_cnt), 64'd0);
    send_frame(8'h02, rand_payload(), NB, 1'b1);
    wait_empty();
    chk("t2_seq_err", 64'(seq_err_cnt), 64'd1);
    chk("t2_frame_cnt", 64'(frame_cnt), 64'd4);
    chk("t2_delivered", 64'(delivered - d0), 64'd4);

    // Short frame (tlast on index 1), then good seq 05
    apply_reset();
    d0 = delivered;
    send_frame(8'h44, rand_payload(), 2, 1'b0);
    chk("t3_len_err_short", 64'(len_err_cnt), 64'd1);
    send_frame(8'h05, rand_payload(), NB, 1'b1);
    wait_empty();
    chk("t3_len_err", 64'(len_err_cnt), 64'd1);
    chk("t3_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t3_delivered", 64'(delivered - d0), 64'd1);

    // Long frame (NB+1 beats) drained, then a good frame
    apply_reset();
    d0 = delivered;
    send_frame(8'h06, rand_payload(), NB + 1, 1'b0);
    chk("t4_len_err_long", 64'(len_err_cnt), 64'd1);
    send_frame(8'h07, rand_payload(), NB, 1'b1);
    wait_empty();
    chk("t4_len_err", 64'(len_err_cnt), 64'd1);
    chk("t4_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t4_delivered", 64'(delivered - d0), 64'd1);

    // Backpressure: two back-to-back frames with the consumer stalled
    apply_reset();
    d0 = delivered;
    data_out_ready = 1'b0;
    pa = rand_payload();
    pb = rand_payload();
    send_frame(8'h20, pa, NB, 1'b1);
    chk("t5_valid_a", 64'(data_out_valid), 64'd1);
    exp_data_q.push_back(pb);
    exp_seq_q.push_back(8'h21);
    fb = build_frame(8'h21, pb);
    for (int b = 0; b < NB - 1; b++) send_beat(fb[b*AW +: AW], 1'b0);
    fork
      send_beat(fb[(NB-1)*AW +: AW], 1'b1);
      begin
        for (int i = 0; i < 13; i++) begin
          @(negedge clk);
          chk("t5_tready_held_low", 64'(tready), 64'd0);
          chk_data("t5_data_stable", data_out, pa);
          chk("t5_seq_stable", 64'(data_out_seq), 64'h20);
        end
        @(posedge clk);
        #1 data_out_ready = 1'b1;
      end
    join
    chk("t5_valid_b", 64'(data_out_valid), 64'd1);
    chk_data("t5_data_b", data_out, pb);
    wait_empty();
    chk("t5_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("t5_delivered", 64'(delivered - d0), 64'd2);
    chk("t5_seq_err", 64'(seq_err_cnt), 64'd0);

    // Reset in mid-frame, then a good frame seq 10
    apply_reset();
    send_frame(8'h30, rand_payload(), NB, 1'b1);
    send_frame(8'h31, rand_payload(), 1, 1'b0);
    send_frame(8'h40, rand_payload(), NB, 1'b1);
    wait_empty();
    chk("t6_pre_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("t6_pre_seq_err", 64'(seq_err_cnt), 64'd1);
    chk("t6_pre_len_err", 64'(len_err_cnt), 64'd1);
    fb = build_frame(8'h50, rand_payload());
    send_beat(fb[AW-1:0], 1'b0);
    send_beat(fb[2*AW-1:AW], 1'b0);
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("t6_rst_seq_err", 64'(seq_err_cnt), 64'd0);
    chk("t6_rst_len_err", 64'(len_err_cnt), 64'd0);
    chk("t6_rst_tready", 64'(tready), 64'd0);
    chk("t6_rst_valid", 64'(data_out_valid), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    d0 = delivered;
    send_frame(8'h10, rand_payload(), NB, 1'b1);
    wait_empty();
    chk("t6_delivered", 64'(delivered - d0), 64'd1);
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t6_seq_err", 64'(seq_err_cnt), 64'd0);
    chk("t6_len_err", 64'(len_err_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
